// File: rtl/spin_motor_ramp_ctrl.sv
// spin_motor_ramp_ctrl
// Washer spin-cycle speed profile: ramp up to a latched target rpm and hold
// there for a number of time-base ticks. It then ramps back down to zero and
// pulses done. A stop request cuts the ramp-up or the hold short.
// Optional build macro: SPIN_BRAKE_EN. When it is defined, a stop-initiated
// ramp-down uses twice the normal step.
module spin_motor_ramp_ctrl #(
  parameter int RAMP_STEP  = 50,
  parameter int HOLD_TICKS = 8,
  parameter int MAX_RPM    = 1400
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic        tick,
  input  logic [10:0] target_speed,
  output logic [10:0] current_rpm,
  output logic [1:0]  state_out,
  output logic        at_speed,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    HOLD      = 2'd2,
    RAMP_DOWN = 2'd3
  } state_t;

  localparam logic [10:0] MAX_C  = 11'(MAX_RPM);
  localparam logic [11:0] STEP_C = 12'(RAMP_STEP);
  localparam logic [7:0]  HOLD_C = 8'(HOLD_TICKS);

  state_t      state_reg, state_next;
  logic [10:0] rpm_reg, rpm_next;
  logic [10:0] tgt_reg, tgt_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic        done_reg, done_next;
  logic [11:0] step_dn;
  logic [11:0] sum_up;
  logic [7:0]  cnt_inc;

`ifdef SPIN_BRAKE_EN
  logic brake_reg, brake_next;

  // Remember whether the current ramp-down was started by a stop request
  always_comb begin
    brake_next = brake_reg;
    if (state_reg == IDLE) begin
      brake_next = 1'b0;
    end else if ((state_reg == RAMP_UP || state_reg == HOLD) && stop) begin
      brake_next = 1'b1;
    end
  end

  // Brake flag register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      brake_reg <= 1'b0;
    end else begin
      brake_reg <= brake_next;
    end
  end

  assign step_dn = brake_reg ? (STEP_C << 1) : STEP_C;
`else
  assign step_dn = STEP_C;
`endif

  // The sum is 12 bits wide so that it cannot wrap before it is clamped to the target
  assign sum_up  = {1'b0, rpm_reg} + STEP_C;
  assign cnt_inc = cnt_reg + 8'd1;

  // Next-state and datapath decisions
  always_comb begin
    state_next = state_reg;
    rpm_next   = rpm_reg;
    tgt_next   = tgt_reg;
    cnt_next   = cnt_reg;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start && !stop) begin
          tgt_next   = (target_speed > MAX_C) ? MAX_C : target_speed;
          state_next = RAMP_UP;
        end
      end
      RAMP_UP: begin
        if (stop) begin
          state_next = RAMP_DOWN;
        end else if (tgt_reg == 11'd0) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end else if (rpm_reg == tgt_reg) begin
          state_next = HOLD;
          cnt_next   = 8'd0;
        end else if (tick) begin
          rpm_next = (sum_up > {1'b0, tgt_reg}) ? tgt_reg : sum_up[10:0];
        end
      end
      HOLD: begin
        if (stop) begin
          state_next = RAMP_DOWN;
        end else if (tick) begin
          cnt_next = cnt_inc;
          if (cnt_inc == HOLD_C) begin
            state_next = RAMP_DOWN;
          end
        end
      end
      RAMP_DOWN: begin
        if (rpm_reg == 11'd0) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end else if (tick) begin
          rpm_next = ({1'b0, rpm_reg} > step_dn) ? 11'({1'b0, rpm_reg} - step_dn) : 11'd0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and datapath registers; reset takes effect without waiting for clk
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      rpm_reg   <= 11'd0;
      tgt_reg   <= 11'd0;
      cnt_reg   <= 8'd0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      rpm_reg   <= rpm_next;
      tgt_reg   <= tgt_next;
      cnt_reg   <= cnt_next;
      done_reg  <= done_next;
    end
  end

  assign current_rpm = rpm_reg;
  assign state_out   = state_reg;
  assign at_speed    = (state_reg == HOLD);
  assign busy        = (state_reg != IDLE);
  assign done        = done_reg;

endmodule

// File: tb/tb_spin_motor_ramp_ctrl.sv
// tb_spin_motor_ramp_ctrl
// Directed bench for spin_motor_ramp_ctrl with default parameters. It applies
// a vector table first and then several hand-written multi-cycle sequences.
// SPIN_BRAKE_EN selects the expected braking step.
module tb_spin_motor_ramp_ctrl;

`ifdef SPIN_BRAKE_EN
  localparam int STEP_DN = 100;
`else
  localparam int STEP_DN = 50;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        tick = 1'b0;
  logic [10:0] target_speed = 11'd0;
  logic [10:0] current_rpm;
  logic [1:0]  state_out;
  logic        at_speed;
  logic        busy;
  logic        done;

  int n_chk = 0;
  int n_fail = 0;
  int done_cnt = 0;

  spin_motor_ramp_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .tick(tick),
    .target_speed(target_speed), .current_rpm(current_rpm), .state_out(state_out),
    .at_speed(at_speed), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st_in;
    logic        sp_in;
    logic        tk_in;
    logic [10:0] ts_in;
    int          rpm;
    int          st;
    logic        dn;
  } vec_t;

  vec_t tbl[24];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // One clock with the given inputs; outputs are then sampled 1 time unit after the edge
  task automatic cyc(input logic s, input logic p, input logic t, input logic [10:0] ts);
    start = s;
    stop = p;
    tick = t;
    target_speed = ts;
    @(posedge clk);
    #1;
    if (done === 1'b1) done_cnt++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_rpm;
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 11'd400, 0,   0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 11'd0,   0,   1, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 11'd0,   0,   0, 1'b1};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 11'd0,   0,   0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 11'd125, 0,   1, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 11'd0,   50,  1, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 11'd0,   50,  1, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 11'd0,   100, 1, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 11'd0,   125, 1, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 11'd0,   125, 2, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 11'd800, 125, 2, 1'b0};
    for (int i = 11; i <= 16; i++) tbl[i] = '{1'b0, 1'b0, 1'b1, 11'd0, 125, 2, 1'b0};
    tbl[17] = '{1'b0, 1'b0, 1'b1, 11'd0,   125, 3, 1'b0};
    tbl[18] = '{1'b0, 1'b1, 1'b1, 11'd0,   75,  3, 1'b0};
    tbl[19] = '{1'b0, 1'b0, 1'b0, 11'd0,   75,  3, 1'b0};
    tbl[20] = '{1'b0, 1'b0, 1'b1, 11'd0,   25,  3, 1'b0};
    tbl[21] = '{1'b0, 1'b0, 1'b1, 11'd0,   0,   3, 1'b0};
    tbl[22] = '{1'b0, 1'b0, 1'b0, 11'd0,   0,   0, 1'b1};
    tbl[23] = '{1'b0, 1'b0, 1'b0, 11'd0,   0,   0, 1'b0};

    // Reset state
    #2;
    chk("reset_rpm", 32'(current_rpm), 0);
    chk("reset_state", 32'(state_out), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    @(posedge clk);
    #3 reset = 1'b0;

    // Vector table: IDLE start+stop, zero target, short ramp, hold timeout, ramp down
    for (int i = 0; i < 24; i++) begin
      cyc(tbl[i].st_in, tbl[i].sp_in, tbl[i].tk_in, tbl[i].ts_in);
      chk($sformatf("vec%0d_rpm", i), 32'(current_rpm), 32'(tbl[i].rpm));
      chk($sformatf("vec%0d_state", i), 32'(state_out), 32'(tbl[i].st));
      chk($sformatf("vec%0d_done", i), 32'(done), 32'(tbl[i].dn));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].st != 0));
      chk($sformatf("vec%0d_atspd", i), 32'(at_speed), 32'(tbl[i].st == 2));
    end

    // Target 400 with a tick every 4 clocks: full up/hold/down profile
    done_cnt = 0;
    cyc(1'b1, 1'b0, 1'b0, 11'd400);
    chk("p400_start", 32'(state_out), 1);
    for (int i = 1; i <= 8; i++) begin
      repeat (3) cyc(1'b0, 1'b0, 1'b0, 11'd0);
      cyc(1'b0, 1'b0, 1'b1, 11'd0);
      chk($sformatf("p400_up%0d", i), 32'(current_rpm), 32'(50 * i));
    end
    cyc(1'b0, 1'b0, 1'b0, 11'd0);
    chk("p400_hold", 32'(state_out), 2);
    chk("p400_atspd", 32'(at_speed), 1);
    for (int i = 1; i <= 8; i++) begin
      repeat (3) cyc(1'b0, 1'b0, 1'b0, 11'd0);
      cyc(1'b0, 1'b0, 1'b1, 11'd0);
      chk($sformatf("p400_hold%0d", i), 32'(state_out), (i < 8) ? 2 : 3);
    end
    for (int i = 1; i <= 8; i++) begin
      repeat (3) cyc(1'b0, 1'b0, 1'b0, 11'd0);
      cyc(1'b0, 1'b0, 1'b1, 11'd0);
      chk($sformatf("p400_dn%0d", i), 32'(current_rpm), 32'(400 - 50 * i));
    end
    cyc(1'b0, 1'b0, 1'b0, 11'd0);
    chk("p400_idle", 32'(state_out), 0);
    chk("p400_done", 32'(done), 1);
    cyc(1'b0, 1'b0, 1'b0, 11'd0);
    chk("p400_busy", 32'(busy), 0);
    chk("p400_donecnt", 32'(done_cnt), 1);

    // Target 1500 clamps to 1400; start in HOLD ignored; asynchronous reset mid-HOLD
    cyc(1'b1, 1'b0, 1'b0, 11'd1500);
    for (int i = 1; i <= 28; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 11'd1500);
      if (i == 27) chk("clamp_t27", 32'(current_rpm), 1350);
    end
    chk("clamp_t28", 32'(current_rpm), 1400);
    chk("clamp_t28_state", 32'(state_out), 1);
    cyc(1'b0, 1'b0, 1'b1, 11'd1500);
    chk("clamp_hold", 32'(state_out), 2);
    chk("clamp_rpm_kept", 32'(current_rpm), 1400);
    cyc(1'b1, 1'b0, 1'b1, 11'd800);
    chk("hold_start_state", 32'(state_out), 2);
    chk("hold_start_rpm", 32'(current_rpm), 1400);
    #2 reset = 1'b1;
    #1;
    chk("areset_rpm", 32'(current_rpm), 0);
    chk("areset_state", 32'(state_out), 0);
    chk("areset_atspd", 32'(at_speed), 0);
    chk("areset_busy", 32'(busy), 0);
    #2 reset = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, 11'd800);
    chk("post_reset_start", 32'(state_out), 1);
    for (int i = 1; i <= 16; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 11'd0);
      if (i == 1) chk("post_reset_t1", 32'(current_rpm), 50);
    end
    chk("post_reset_800", 32'(current_rpm), 800);
    cyc(1'b0, 1'b0, 1'b0, 11'd0);
    chk("post_reset_hold", 32'(state_out), 2);
    cyc(1'b0, 1'b1, 1'b0, 11'd0);
    chk("hold_stop", 32'(state_out), 3);
    exp_rpm = 800;
    for (int i = 0; i < 20 && exp_rpm > 0; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 11'd0);
      exp_rpm = (exp_rpm > STEP_DN) ? exp_rpm - STEP_DN : 0;
      chk("hold_stop_dn", 32'(current_rpm), 32'(exp_rpm));
    end
    cyc(1'b0, 1'b0, 1'b0, 11'd0);
    chk("hold_stop_done", 32'(done), 1);

    // Target 425: the last ramp step is clipped to the target
    cyc(1'b1, 1'b0, 1'b0, 11'd425);
    for (int i = 1; i <= 9; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 11'd0);
      if (i == 8) chk("t425_8", 32'(current_rpm), 400);
    end
    chk("t425_9", 32'(current_rpm), 425);
    cyc(1'b0, 1'b0, 1'b0, 11'd0);
    chk("t425_hold", 32'(state_out), 2);
    cyc(1'b0, 1'b1, 1'b1, 11'd0);
    chk("t425_stop_state", 32'(state_out), 3);
    chk("t425_stop_rpm", 32'(current_rpm), 425);
    exp_rpm = 425;
    for (int i = 0; i < 20 && exp_rpm > 0; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 11'd0);
      exp_rpm = (exp_rpm > STEP_DN) ? exp_rpm - STEP_DN : 0;
      chk("t425_dn", 32'(current_rpm), 32'(exp_rpm));
    end
    cyc(1'b0, 1'b0, 1'b0, 11'd0);
    chk("t425_idle", 32'(state_out), 0);

    // Target 1200, stop at 600 overrides the same-cycle tick; a second stop in RAMP_DOWN does nothing
    cyc(1'b1, 1'b0, 1'b0, 11'd1200);
    for (int i = 1; i <= 12; i++) cyc(1'b0, 1'b0, 1'b1, 11'd0);
    chk("s1200_600", 32'(current_rpm), 600);
    cyc(1'b0, 1'b1, 1'b1, 11'd0);
    chk("s1200_stop_state", 32'(state_out), 3);
    chk("s1200_stop_rpm", 32'(current_rpm), 600);
    for (int i = 1; i <= 600 / STEP_DN; i++) begin
      cyc(1'b0, (i == 2), 1'b1, 11'd0);
      chk($sformatf("s1200_dn%0d", i), 32'(current_rpm), 32'(600 - i * STEP_DN));
      chk($sformatf("s1200_st%0d", i), 32'(state_out), 3);
    end
    cyc(1'b0, 1'b0, 1'b0, 11'd0);
    chk("s1200_idle", 32'(state_out), 0);
    chk("s1200_done", 32'(done), 1);
    cyc(1'b0, 1'b0, 1'b0, 11'd0);
    chk("s1200_done_off", 32'(done), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/spin_motor_ramp_ctrl.md
SPIN_MOTOR_RAMP_CTRL -- requirements
Module: spin_motor_ramp_ctrl

Interface
REQ-001: Parameter RAMP_STEP, default 50, rpm change per tick during ramping (1..255) SHALL be provided.
REQ-002: Parameter HOLD_TICKS, default 8, number of ticks held at target speed (1..255) SHALL be provided.
REQ-003: Parameter MAX_RPM, default 1400, upper clamp for the latched target SHALL be provided.
REQ-004: clk  input  1  clock; all state changes on rising edge.
REQ-005: reset  input  1  reset, asynchronous, active-high.
REQ-006: start  input  1  level; begins a spin cycle when sampled high in IDLE.
REQ-007: stop  input  1  level; requests ramp-down when sampled high in RAMP_UP or HOLD.
REQ-008: tick  input  1  single-cycle ramp/hold time-base strobe.
REQ-009: target_speed  input  11  requested rpm, typically 400/800/1200/1400 from the spin-speed selector.
REQ-010: current_rpm  output  11  registered commanded motor rpm.
REQ-011: state_out  output  2  current state: 0 IDLE, 1 RAMP_UP, 2 HOLD, 3 RAMP_DOWN.
REQ-012: at_speed  output  1  high while in HOLD.
REQ-013: busy  output  1  high in any state other than IDLE.
REQ-014: done  output  1  one-cycle pulse when a cycle ends and the block returns to IDLE.

Function
REQ-015: IDLE with start=1 and stop=0 SHALL latch tgt = min(target_speed, MAX_RPM) and enter RAMP_UP next cycle; target_speed changes afterwards SHALL be ignored until the next start.
REQ-016: start and stop both high in IDLE SHALL leave the block in IDLE (stop wins); start outside IDLE SHALL be ignored.
REQ-017: Latched tgt equal to 0 SHALL go IDLE -> RAMP_UP -> IDLE with done pulsed on return, without any tick required.
REQ-018: RAMP_UP on each tick SHALL set current_rpm = min(current_rpm + RAMP_STEP, tgt), sum computed at 12 bits (no wrap).
REQ-019: RAMP_UP SHALL enter HOLD in the cycle after current_rpm equals tgt, clearing the hold counter.
REQ-020: HOLD SHALL count ticks and enter RAMP_DOWN on the tick that makes the count equal HOLD_TICKS.
REQ-021: stop=1 in RAMP_UP or HOLD SHALL enter RAMP_DOWN next cycle, overriding any tick in that cycle; stop in RAMP_DOWN or IDLE SHALL have no effect.
REQ-022: RAMP_DOWN on each tick SHALL set current_rpm = max(current_rpm - step_dn, 0) with no underflow; step_dn = RAMP_STEP unless modified by REQ-028.
REQ-023: RAMP_DOWN reaching current_rpm = 0 SHALL return to IDLE next cycle and pulse done for exactly that one cycle.
REQ-024: current_rpm SHALL change only on tick cycles; no tick means the value holds.
REQ-025: busy, at_speed, state_out SHALL be decoded from the registered state (no combinational path from inputs).

Reset
REQ-026: reset asserted SHALL immediately force IDLE, current_rpm=0, tgt=0, hold counter=0, done=0, at_speed=0, busy=0, state_out=0, including mid-ramp or mid-hold.
REQ-027: First rising edge after reset deassertion SHALL evaluate start normally (no extra dead cycle).

Configuration
REQ-028: Macro SPIN_BRAKE_EN defined SHALL make RAMP_DOWN entered via stop use step_dn = 2*RAMP_STEP; RAMP_DOWN entered from HOLD timeout still uses RAMP_STEP; undefined, step_dn is always RAMP_STEP.

Verification
REQ-029: tgt 400, default params, tick every 4 clk -> 8 ticks up to 400, at_speed for 8 ticks, 8 ticks down to 0, single done pulse, busy low afterwards.
REQ-030: target_speed 1500 -> latched tgt 1400, ramp ends at 1400 after 28 ticks; target_speed 425 -> rpm 400 at tick 8, 425 at tick 9, then HOLD.
REQ-031: tgt 1200, stop asserted at rpm 600 -> RAMP_DOWN next cycle, 12 ticks to 0 (6 with SPIN_BRAKE_EN), done pulse; stop asserted again in RAMP_DOWN -> no change.
REQ-032: start+stop together in IDLE -> stays IDLE, busy 0; start during HOLD with new target_speed 800 -> ignored, tgt unchanged.
REQ-033: reset asserted mid-HOLD at 1400 -> current_rpm 0, state_out 0, at_speed 0 without waiting for clk; next start with 800 ramps normally.
REQ-034: target_speed 0 with start -> done pulse within 2 cycles, current_rpm stays 0.
